// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way set-associative write-through, no-write-allocate data cache
// Read hits return in the same cycle; misses and all stores go to the SRAM controller.
module cache_controller #(
    parameter int SETS  = 64,
    parameter int TAG_W = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        sram_read_en,
    output logic        sram_write_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_writeData,
    input  logic [31:0] sram_readData,
    input  logic        sram_ready
);

    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL0 = 2'd1,
        FILL1 = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        entry_q, entry_d;
    logic        victim_q, victim_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_data_q, req_data_d;
    logic        sram_read_en_q, sram_read_en_d;
    logic        sram_write_en_q, sram_write_en_d;
    logic [31:0] sram_address_q, sram_address_d;
    logic [31:0] sram_writeData_q, sram_writeData_d;

    logic             valid_q [2][SETS];
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [31:0]      word_q  [2][SETS][2];
    logic [SETS-1:0]  lru_q;

    // In IDLE the live request is looked up; during a store the latched one is.
    logic [31:0]      lk_addr;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_wsel;
    logic             hit0, hit1, hit;
    logic             victim;
    logic             done;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             rd_hit_upd;
    logic             wr_hit_upd;
    logic             unused_bits;

    assign lk_addr  = (state_q == IDLE) ? address : req_addr_q;
    assign lk_idx   = lk_addr[3 +: IDX_W];
    assign lk_tag   = lk_addr[3 + IDX_W +: TAG_W];
    assign lk_wsel  = lk_addr[2];
    assign hit0     = valid_q[0][lk_idx] && (tag_q[0][lk_idx] == lk_tag);
    assign hit1     = valid_q[1][lk_idx] && (tag_q[1][lk_idx] == lk_tag);
    assign hit      = hit0 || hit1;
    assign victim   = !valid_q[0][lk_idx] ? 1'b0 :
                      !valid_q[1][lk_idx] ? 1'b1 : lru_q[lk_idx];
    assign done     = !entry_q && sram_ready;
    assign fill_idx = req_addr_q[3 +: IDX_W];
    assign fill_tag = req_addr_q[3 + IDX_W +: TAG_W];

    assign rd_hit_upd = (state_q == IDLE) && read_en && !write_en && hit;
    assign wr_hit_upd = (state_q == WRITE) && done && hit;

    assign unused_bits = ^{address[1:0], req_addr_q[1:0]};

    always_comb begin
        ready    = 1'b0;
        readData = 32'd0;
        case (state_q)
            IDLE: begin
                if (write_en) begin
                    ready = 1'b0;
                end else if (read_en) begin
                    ready = hit;
                end else begin
                    ready = 1'b1;
                end
                if (rd_hit_upd) begin
                    readData = hit0 ? word_q[0][lk_idx][lk_wsel] : word_q[1][lk_idx][lk_wsel];
                end
            end
            WRITE:   ready = done;
            default: ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        entry_d          = 1'b0;
        victim_d         = victim_q;
        req_addr_d       = req_addr_q;
        req_data_d       = req_data_q;
        sram_read_en_d   = sram_read_en_q;
        sram_write_en_d  = sram_write_en_q;
        sram_address_d   = sram_address_q;
        sram_writeData_d = sram_writeData_q;
        case (state_q)
            IDLE: begin
                if (write_en) begin
                    state_d          = WRITE;
                    entry_d          = 1'b1;
                    req_addr_d       = address;
                    req_data_d       = writeData;
                    sram_write_en_d  = 1'b1;
                    sram_address_d   = {address[31:2], 2'b00};
                    sram_writeData_d = writeData;
                end else if (read_en && !hit) begin
                    state_d        = FILL0;
                    entry_d        = 1'b1;
                    req_addr_d     = address;
                    victim_d       = victim;
                    sram_read_en_d = 1'b1;
                    sram_address_d = {address[31:3], 3'b000};
                end
            end
            FILL0: begin
                if (done) begin
                    state_d        = FILL1;
                    entry_d        = 1'b1;
                    sram_address_d = {req_addr_q[31:3], 3'b100};
                end
            end
            FILL1: begin
                if (done) begin
                    state_d        = IDLE;
                    sram_read_en_d = 1'b0;
                end
            end
            WRITE: begin
                if (done) begin
                    state_d         = IDLE;
                    sram_write_en_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            entry_q          <= 1'b0;
            victim_q         <= 1'b0;
            req_addr_q       <= 32'd0;
            req_data_q       <= 32'd0;
            sram_read_en_q   <= 1'b0;
            sram_write_en_q  <= 1'b0;
            sram_address_q   <= 32'd0;
            sram_writeData_q <= 32'd0;
            lru_q            <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[0][s] <= 1'b0;
                valid_q[1][s] <= 1'b0;
            end
        end else begin
            state_q          <= state_d;
            entry_q          <= entry_d;
            victim_q         <= victim_d;
            req_addr_q       <= req_addr_d;
            req_data_q       <= req_data_d;
            sram_read_en_q   <= sram_read_en_d;
            sram_write_en_q  <= sram_write_en_d;
            sram_address_q   <= sram_address_d;
            sram_writeData_q <= sram_writeData_d;
            // LRU bit names the way to replace next, i.e. the one not just touched.
            if (rd_hit_upd || wr_hit_upd) begin
                lru_q[lk_idx] <= hit0;
            end
            if ((state_q == FILL1) && done) begin
                valid_q[victim_q][fill_idx] <= 1'b1;
                lru_q[fill_idx]             <= ~victim_q;
            end
        end
    end

    // Tags and data need no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((state_q == FILL0) && done) begin
                word_q[victim_q][fill_idx][0] <= sram_readData;
            end
            if ((state_q == FILL1) && done) begin
                word_q[victim_q][fill_idx][1] <= sram_readData;
                tag_q[victim_q][fill_idx]     <= fill_tag;
            end
            if (wr_hit_upd) begin
                word_q[hit1][lk_idx][lk_wsel] <= req_data_q;
            end
        end
    end

    assign sram_read_en   = sram_read_en_q;
    assign sram_write_en  = sram_write_en_q;
    assign sram_address   = sram_address_q;
    assign sram_writeData = sram_writeData_q;

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed scoreboard bench for cache_controller
// A small SRAM model logs every completed access for comparison against expectations.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en;
    logic        write_en;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    logic        sram_read_en;
    logic        sram_write_en;
    logic [31:0] sram_address;
    logic [31:0] sram_writeData;
    logic [31:0] sram_readData = 32'd0;
    logic        sram_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        obs_q[$];
    acc_t        exp_acc_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] mem [int];

    logic mdl_busy = 1'b0;
    int   mdl_cnt  = 0;

    cache_controller dut (
        .clk           (clk),
        .rst           (rst),
        .read_en       (read_en),
        .write_en      (write_en),
        .address       (address),
        .writeData     (writeData),
        .readData      (readData),
        .ready         (ready),
        .sram_read_en  (sram_read_en),
        .sram_write_en (sram_write_en),
        .sram_address  (sram_address),
        .sram_writeData(sram_writeData),
        .sram_readData (sram_readData),
        .sram_ready    (sram_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // SRAM model: idle ready=1, then 0 for two cycles per access, then one completion cycle.
    always @(posedge clk) begin
        if (!(sram_read_en || sram_write_en)) begin
            sram_ready <= 1'b1;
            mdl_busy   <= 1'b0;
        end else if (!mdl_busy) begin
            mdl_busy      <= 1'b1;
            sram_ready    <= 1'b0;
            mdl_cnt       <= 0;
            sram_readData <= mem.exists(int'(sram_address)) ? mem[int'(sram_address)] : dflt(sram_address);
        end else if (sram_ready) begin
            obs_q.push_back({sram_write_en, sram_address, sram_write_en ? sram_writeData : sram_readData});
            if (sram_write_en) mem[int'(sram_address)] = sram_writeData;
            mdl_busy   <= 1'b0;
            sram_ready <= 1'b0;
        end else if (mdl_cnt == 1) begin
            sram_ready <= 1'b1;
        end else begin
            mdl_cnt <= mdl_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_accesses(input logic [31:0] a);
        int n;
        chk($sformatf("acc_count@%h", a), obs_q.size(), exp_acc_q.size());
        n = (obs_q.size() < exp_acc_q.size()) ? obs_q.size() : exp_acc_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("acc%0d_we@%h", i, a), {31'd0, obs_q[i].we}, {31'd0, exp_acc_q[i].we});
            chk($sformatf("acc%0d_addr@%h", i, a), obs_q[i].addr, exp_acc_q[i].addr);
            if (exp_acc_q[i].we) chk($sformatf("acc%0d_wdata@%h", i, a), obs_q[i].data, exp_acc_q[i].data);
        end
        exp_acc_q.delete();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input bit miss);
        int          cyc;
        logic [31:0] e;
        exp_data_q.push_back(exp);
        if (miss) begin
            exp_acc_q.push_back({1'b0, a[31:3], 3'b000, 32'd0});
            exp_acc_q.push_back({1'b0, a[31:3], 3'b100, 32'd0});
        end
        @(negedge clk);
        obs_q.delete();
        address = a;
        read_en = 1'b1;
        #1;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk($sformatf("rd_timeout@%h", a), {31'd0, cyc >= 100}, 32'd0);
        e = exp_data_q.pop_front();
        chk($sformatf("rd_data@%h", a), readData, e);
        chk($sformatf("rd_miss@%h", a), {31'd0, cyc != 0}, {31'd0, miss});
        @(posedge clk);
        #1;
        read_en = 1'b0;
        check_accesses(a);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int cyc;
        bit held;
        exp_acc_q.push_back({1'b1, a[31:2], 2'b00, d});
        @(negedge clk);
        obs_q.delete();
        address   = a;
        writeData = d;
        write_en  = 1'b1;
        #1;
        chk($sformatf("wr_ready_low@%h", a), {31'd0, ready}, 32'd0);
        cyc  = 0;
        held = 1'b1;
        do begin
            @(negedge clk);
            #1;
            cyc++;
            if (sram_write_en !== 1'b1) held = 1'b0;
        end while (ready !== 1'b1 && cyc < 100);
        chk($sformatf("wr_timeout@%h", a), {31'd0, cyc >= 100}, 32'd0);
        chk($sformatf("wr_en_held@%h", a), {31'd0, held}, 32'd1);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        #1;
        chk($sformatf("wr_en_drop@%h", a), {31'd0, sram_write_en}, 32'd0);
        check_accesses(a);
    endtask

    initial begin
        int cyc;
        mem[32'h100] = 32'hAAAA_0001;
        mem[32'h104] = 32'hBBBB_0002;
        rst       = 1'b1;
        read_en   = 1'b0;
        write_en  = 1'b0;
        address   = 32'd0;
        writeData = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_rdata", readData, 32'd0);
        chk("rst_sram_rd", {31'd0, sram_read_en}, 32'd0);
        chk("rst_sram_wr", {31'd0, sram_write_en}, 32'd0);
        chk("rst_sram_addr", sram_address, 32'd0);
        chk("rst_sram_wdata", sram_writeData, 32'd0);

        do_read(32'h104, 32'hBBBB_0002, 1'b1);
        do_read(32'h100, 32'hAAAA_0001, 1'b0);
        do_read(32'h300, dflt(32'h300), 1'b1);
        do_read(32'h100, 32'hAAAA_0001, 1'b0);
        do_read(32'h500, dflt(32'h500), 1'b1);
        do_read(32'h100, 32'hAAAA_0001, 1'b0);
        do_read(32'h300, dflt(32'h300), 1'b1);
        do_read(32'h304, dflt(32'h304), 1'b0);

        do_write(32'h104, 32'hDEAD_BEEF);
        do_read(32'h104, 32'hDEAD_BEEF, 1'b0);
        do_read(32'h100, 32'hAAAA_0001, 1'b0);

        do_write(32'h900, 32'h1234_5678);
        do_read(32'h900, 32'h1234_5678, 1'b1);
        do_read(32'h904, dflt(32'h904), 1'b0);

        @(negedge clk);
        address = 32'h2000;
        read_en = 1'b1;
        cyc = 0;
        while (!(sram_read_en === 1'b1 && sram_address === 32'h2004) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("fill1_reached", {31'd0, cyc >= 100}, 32'd0);
        rst     = 1'b1;
        read_en = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_sram_rd", {31'd0, sram_read_en}, 32'd0);
        chk("midrst_sram_wr", {31'd0, sram_write_en}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_read(32'h2000, dflt(32'h2000), 1'b1);
        do_read(32'h100, 32'hAAAA_0001, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
